// File: rtl/program_loader.sv
// Streams a host byte image (count header, LE payload words, XOR checksum) into main_memory
// and keeps the CPU held in reset until an image has been written and verified.
module program_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int unsigned MAX_WORDS = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        start,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic        mem_wen,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error,
   output logic [31:0] words_loaded
);

   localparam logic [2:0] S_HDR  = 3'd0;
   localparam logic [2:0] S_DATA = 3'd1;
   localparam logic [2:0] S_CSUM = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   localparam logic [31:0] L_MAX_WORDS = 32'(MAX_WORDS);

   logic [2:0]  r_state;
   logic [1:0]  r_byte_idx;
   logic [31:0] r_count;
   logic [23:0] r_word;
   logic [7:0]  r_xor;
   logic        r_mem_wen;
   logic [31:0] r_mem_waddr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_words_loaded;

   logic        w_loading;
   logic        w_accept;
   logic        w_last_byte;
   logic [31:0] w_full_count;
   logic [31:0] w_full_word;
   logic [7:0]  w_xor_next;
   logic        w_last_word;

   assign w_loading   = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
   assign w_accept    = in_valid && w_loading;
   assign w_last_byte = (r_byte_idx == 2'd3);
   assign w_xor_next  = r_xor ^ in_data;

   // Bytes arrive LSB first, so shifting in from the top leaves byte 0 in bits [7:0].
   assign w_full_count = {in_data, r_count[31:8]};
   assign w_full_word  = {in_data, r_word};
   assign w_last_word  = ((r_words_loaded + 32'd1) == r_count);

   // NOTE: every register below is assigned with <= so all of them update together on
   // the edge; a blocking = would let later statements see half-updated state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_HDR;
         r_byte_idx     <= 2'd0;
         r_count        <= 32'd0;
         r_word         <= 24'd0;
         r_xor          <= 8'd0;
         r_mem_wen      <= 1'b0;
         r_mem_waddr    <= 32'd0;
         r_mem_wdata    <= 32'd0;
         r_words_loaded <= 32'd0;
      end else begin
         r_mem_wen <= 1'b0;
         case (r_state)
            S_HDR: begin
               if (w_accept) begin
                  r_xor      <= w_xor_next;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  r_count    <= w_full_count;
                  if (w_last_byte) begin
                     if (w_full_count == 32'd0) begin
                        r_state <= S_CSUM;
                     end else if (w_full_count > L_MAX_WORDS) begin
                        r_state <= S_ERR;
                     end else begin
                        r_state <= S_DATA;
                     end
                  end
               end
            end

            S_DATA: begin
               if (w_accept) begin
                  r_xor      <= w_xor_next;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  r_word     <= {in_data, r_word[23:8]};
                  if (w_last_byte) begin
                     r_mem_wen      <= 1'b1;
                     r_mem_waddr    <= BASE_ADDR + r_words_loaded;
                     r_mem_wdata    <= w_full_word;
                     r_words_loaded <= r_words_loaded + 32'd1;
                     if (w_last_word) begin
                        r_state <= S_CSUM;
                     end
                  end
               end
            end

            S_CSUM: begin
               if (w_accept) begin
                  r_state <= (in_data == r_xor) ? S_DONE : S_ERR;
               end
            end

            S_DONE, S_ERR: begin
               // Re-arm keeps the last memory address/data visible; only the load state clears.
               if (start) begin
                  r_state        <= S_HDR;
                  r_byte_idx     <= 2'd0;
                  r_count        <= 32'd0;
                  r_word         <= 24'd0;
                  r_xor          <= 8'd0;
                  r_words_loaded <= 32'd0;
               end
            end

            default: begin
               r_state <= S_ERR;
            end
         endcase
      end
   end

   assign in_ready     = w_loading;
   assign mem_wen      = r_mem_wen;
   assign mem_waddr    = r_mem_waddr;
   assign mem_wdata    = r_mem_wdata;
   assign cpu_hold     = (r_state != S_DONE);
   assign load_done    = (r_state == S_DONE);
   assign load_error   = (r_state == S_ERR);
   assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: byte streams are driven with random gaps and the
// resulting memory writes and flags are compared with a stream-level reference model.
`timescale 1ns/1ps
module tb_program_loader;

   localparam logic [31:0] BASE = 32'h0;
   localparam int unsigned MAXW = 2048;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        start;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_wen;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;
   logic [31:0] words_loaded;

   program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .start        (start),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_wen      (mem_wen),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int unsigned    n_vec = 0;
   int unsigned    n_err = 0;
   int unsigned    cyc = 0;
   logic [31:0]    wr_addr_q[$];
   logic [31:0]    wr_data_q[$];
   int unsigned    wr_cyc_q[$];
   int unsigned    exp_cyc_q[$];
   logic [7:0]     stim[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst === 1'b1 && mem_wen === 1'b1) begin
         wr_addr_q.push_back(mem_waddr);
         wr_data_q.push_back(mem_wdata);
         wr_cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic build(input logic [31:0] n, input bit good_sum);
      logic [7:0] x;
      stim.delete();
      for (int k = 0; k < 4; k++) stim.push_back(n[8*k +: 8]);
      if (n > 32'(MAXW)) return;
      for (int k = 0; k < 4 * int'(n); k++) stim.push_back(8'($urandom));
      x = 8'd0;
      foreach (stim[k]) x ^= stim[k];
      stim.push_back(good_sum ? x : (x ^ 8'($urandom_range(1, 255))));
   endtask

   task automatic set_t1(input logic [7:0] csum);
      logic [7:0] t1[12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE};
      stim.delete();
      foreach (t1[k]) stim.push_back(t1[k]);
      stim.push_back(csum);
   endtask

   // Drives the first `count` bytes of stim; returns 0 if the loader refused a byte.
   task automatic send_bytes(input string name, input int count, input int gap_pct,
                             output bit ok);
      logic [31:0] n;
      bit          bad;
      n   = {stim[3], stim[2], stim[1], stim[0]};
      bad = (n > 32'(MAXW));
      ok  = 1'b1;
      for (int i = 0; i < count; i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            start    = ($urandom_range(3) == 0) && i > 0;
            @(negedge clk);
         end
         start    = (i > 0 && i < stim.size() - 1) ? ($urandom_range(3) == 0) : 1'b0;
         in_valid = 1'b1;
         in_data  = stim[i];
         check($sformatf("%s ready byte%0d", name, i), 32'(in_ready), 32'd1);
         if (in_ready !== 1'b1) begin
            ok = 1'b0;
            break;
         end
         @(posedge clk);
         @(negedge clk);
         if (!bad && i >= 4 && i < 4 + 4 * int'(n) && ((i - 4) % 4) == 3)
            exp_cyc_q.push_back(cyc);
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic run_stream(input string name, input int gap_pct);
      logic [31:0] n;
      logic [31:0] nw;
      logic [7:0]  x;
      bit          bad;
      bit          good;
      bit          ok;
      n   = {stim[3], stim[2], stim[1], stim[0]};
      bad = (n > 32'(MAXW));
      nw  = bad ? 32'd0 : n;
      x   = 8'd0;
      for (int k = 0; k < stim.size() - 1; k++) x ^= stim[k];
      good = !bad && (x == stim[stim.size() - 1]);
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      exp_cyc_q.delete();
      send_bytes(name, stim.size(), gap_pct, ok);
      if (!ok) return;
      @(negedge clk);
      check({name, " done"},  32'(load_done),  32'(good));
      check({name, " error"}, 32'(load_error), 32'(!good));
      check({name, " hold"},  32'(cpu_hold),   32'(!good));
      check({name, " ready"}, 32'(in_ready),   32'd0);
      check({name, " words"}, words_loaded,    nw);
      check({name, " nwrites"}, 32'(wr_addr_q.size()), nw);
      for (int i = 0; i < int'(nw) && i < wr_addr_q.size(); i++) begin
         check($sformatf("%s addr%0d", name, i), wr_addr_q[i], BASE + 32'(i));
         check($sformatf("%s data%0d", name, i), wr_data_q[i],
               {stim[4*i+7], stim[4*i+6], stim[4*i+5], stim[4*i+4]});
         if (i < exp_cyc_q.size())
            check($sformatf("%s when%0d", name, i), wr_cyc_q[i], exp_cyc_q[i]);
      end
      // Bytes offered after completion must be refused and change nothing.
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check({name, " idle ready"}, 32'(in_ready),  32'd0);
      check({name, " idle words"}, words_loaded,    nw);
      check({name, " idle done"},  32'(load_done),  32'(good));
   endtask

   task automatic rearm(input string name);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, " rearm hold"},  32'(cpu_hold),   32'd1);
      check({name, " rearm done"},  32'(load_done),  32'd0);
      check({name, " rearm err"},   32'(load_error), 32'd0);
      check({name, " rearm words"}, words_loaded,    32'd0);
      check({name, " rearm ready"}, 32'(in_ready),   32'd1);
   endtask

   task automatic check_reset_values(input string name);
      check({name, " hold"},  32'(cpu_hold),   32'd1);
      check({name, " done"},  32'(load_done),  32'd0);
      check({name, " err"},   32'(load_error), 32'd0);
      check({name, " words"}, words_loaded,    32'd0);
      check({name, " wen"},   32'(mem_wen),    32'd0);
      check({name, " waddr"}, mem_waddr,       32'd0);
      check({name, " wdata"}, mem_wdata,       32'd0);
      check({name, " ready"}, 32'(in_ready),   32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          ok;
      logic [31:0] n;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      start    = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b1;
      @(negedge clk);

      set_t1(8'h28);  run_stream("t1", 0);        rearm("t1");
      set_t1(8'h29);  run_stream("t2", 0);        rearm("t2");
      build(32'd2049, 1'b1); run_stream("t3", 0); rearm("t3");
      build(32'd0, 1'b1);    run_stream("t4", 0); rearm("t4");
      set_t1(8'h28);  run_stream("t5gap", 40);    rearm("t5gap");

      // Reset after two payload bytes: nothing may be written, everything returns to reset.
      wr_addr_q.delete();
      send_bytes("t5part", 6, 20, ok);
      rst = 1'b0;
      #1;
      check_reset_values("t5rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5rst nwrites", 32'(wr_addr_q.size()), 32'd0);
      set_t1(8'h28);  run_stream("t5replay", 0);  rearm("t5replay");

      build(32'd0, 1'b0);            run_stream("n0bad", 10);  rearm("n0bad");
      build(32'(MAXW), 1'b1);        run_stream("nmax", 0);    rearm("nmax");
      build(32'hFFFF_FFFF, 1'b1);    run_stream("nhuge", 30);  rearm("nhuge");

      for (int t = 0; t < 24; t++) begin
         case ($urandom_range(5))
            0:       n = $urandom | 32'h0000_1000;
            1:       n = 32'd0;
            default: n = 32'($urandom_range(1, 8));
         endcase
         build(n, $urandom_range(3) != 0);
         run_stream($sformatf("rnd%0d", t), int'($urandom_range(0, 50)));
         rearm($sformatf("rnd%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
